mac_feeder: RTL and testbench
=============================

MAC_FEEDER -- requirements
Module: mac_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 8, activation/weight width; accumulator width is 4*DATA_WIDTH (ACC_W).
REQ-002 Clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low; shared with the attached MAC_UNIT.
REQ-004 in_valid  in  1  compressed input beat valid.
REQ-005 in_ready  out  1  feeder accepts beat when in_valid&in_ready at a rising edge.
REQ-006 in_act  in  DATA_WIDTH  activation value.
REQ-007 in_weight  in  DATA_WIDTH  weight value.
REQ-008 in_sel  in  2  target accumulator index 0..3.
REQ-009 in_last  in  1  final beat of the current frame.
REQ-010 Mac_act / Mac_weight  out  DATA_WIDTH each  operands to MAC.
REQ-011 Mac_select  out  2  MAC accumulator select.
REQ-012 Mac_block  out  1  MAC Block_control (1 = accumulate, 0 = expose/clear).
REQ-013 Mac_out_0..Mac_out_3  in  ACC_W each  MAC accumulator outputs (valid only while Mac_block=0).
REQ-014 res_valid  out  1  result beat valid.
REQ-015 res_ready  in  1  result consumer ready.
REQ-016 res_data  out  ACC_W  result value.
REQ-017 res_idx  out  2  accumulator index of res_data.
REQ-018 res_last  out  1  high on the res_idx=3 beat.
REQ-019 skip_cnt  out  16  zero-operand beats dropped in the current/last frame.

Function
REQ-020 FSM states ACCUM, FLUSH, CAPTURE, DRAIN; reset state ACCUM.
REQ-021 ACCUM: in_ready=1, Mac_block=1; every other state: in_ready=0.
REQ-022 Accepted beat with in_act!=0 and in_weight!=0 loads one-entry stage register (act, weight, sel, stage_v=1) at that edge; otherwise stage_v=0 next cycle.
REQ-023 Accepted beat with in_act==0 or in_weight==0: not forwarded, skip_cnt increments (saturates at 0xFFFF).
REQ-024 Stage drives Mac_act/Mac_weight/Mac_select when stage_v=1; when stage_v=0 drives Mac_act=0, Mac_weight=0, Mac_select=0 (no-op accumulate).
REQ-025 Latency: accepted beat reaches MAC in the following cycle; MAC accumulates at the end of that cycle; one beat per cycle sustained.
REQ-026 ACCUM -> FLUSH on accepted beat with in_last=1 (skipped or not).
REQ-027 FLUSH: one cycle, Mac_block=1, stage drains final beat; -> CAPTURE unconditionally; stage_v=0 after.
REQ-028 CAPTURE: one cycle, Mac_block=0, Mac_act/Mac_weight=0; Mac_out_0..3 latched into cap[0..3] at end of cycle (MAC clears at same edge); -> DRAIN.
REQ-029 DRAIN: Mac_block=1, res_valid=1, res_data=cap[idx], res_idx=idx, res_last=(idx==3); idx starts 0.
REQ-030 Beat transfers when res_valid&res_ready; idx increments; res_data/res_idx held stable while res_ready=0.
REQ-031 Transfer with idx=3 -> ACCUM, idx=0, skip_cnt cleared to 0 at that edge.
REQ-032 res_valid first high 2 cycles after the in_last acceptance edge; frame turnaround minimum 7 cycles last-accept to next accept (FLUSH, CAPTURE, 4 DRAIN, first ACCUM cycle).
REQ-033 res_data wraps modulo 2^ACC_W as produced by MAC; feeder performs no arithmetic on it.
REQ-034 in_valid while in_ready=0 has no effect; inputs ignored outside ACCUM.

Reset
REQ-035 rst=0 at any edge, any state: state=ACCUM, stage_v=0, idx=0, cap[*]=0, skip_cnt=0.
REQ-036 Outputs during/after reset: in_ready=1, Mac_block=1, Mac_act=0, Mac_weight=0, Mac_select=0, res_valid=0, res_data=0, res_idx=0, res_last=0.
REQ-037 Reset mid-frame or mid-DRAIN discards partial results; no res beat emitted for that frame.

Verification
REQ-038 Frame (3,4,sel0),(2,5,sel1),(1,1,sel3,last), res_ready=1 -> res beats 12,10,0,1 with idx 0..3, res_last on 4th, skip_cnt=0.
REQ-039 Frame (5,0,sel2),(0,7,sel2),(6,6,sel2,last) -> res 0,0,36,0; skip_cnt=2 until final transfer, then 0.
REQ-040 Single beat (255,255,sel1,last), res_ready low 5 cycles in DRAIN -> idx0 value 0 held stable 5 cycles; then 0,65025,0,0.
REQ-041 Two back-to-back frames with same sel -> second frame results exclude first frame (MAC cleared in CAPTURE).
REQ-042 rst=0 for one cycle during DRAIN idx=2 -> res_valid=0 next cycle, in_ready=1; next frame (2,3,sel0,last) -> 6,0,0,0.
REQ-043 in_valid held high during FLUSH/CAPTURE/DRAIN with last=1 -> no beat accepted until ACCUM; timing per REQ-032.

Source files
------------

// File: rtl/mac_feeder_if.sv
// Bundle of the feeder's three buses: compressed input stream, MAC operand /
// result wires, and the result stream to the downstream consumer.
interface mac_feeder_if #(parameter int DATA_WIDTH = 8);
  localparam int ACC_W = 4 * DATA_WIDTH;

  // compressed input stream
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_act;
  logic [DATA_WIDTH-1:0] in_weight;
  logic [1:0]            in_sel;
  logic                  in_last;
  // MAC unit side
  logic [DATA_WIDTH-1:0] Mac_act;
  logic [DATA_WIDTH-1:0] Mac_weight;
  logic [1:0]            Mac_select;
  logic                  Mac_block;
  logic [ACC_W-1:0]      Mac_out_0;
  logic [ACC_W-1:0]      Mac_out_1;
  logic [ACC_W-1:0]      Mac_out_2;
  logic [ACC_W-1:0]      Mac_out_3;
  // result stream
  logic                  res_valid;
  logic                  res_ready;
  logic [ACC_W-1:0]      res_data;
  logic [1:0]            res_idx;
  logic                  res_last;
  logic [15:0]           skip_cnt;

  modport slave (
    input  in_valid, in_act, in_weight, in_sel, in_last,
    input  Mac_out_0, Mac_out_1, Mac_out_2, Mac_out_3,
    input  res_ready,
    output in_ready, Mac_act, Mac_weight, Mac_select, Mac_block,
    output res_valid, res_data, res_idx, res_last, skip_cnt
  );

  modport master (
    output in_valid, in_act, in_weight, in_sel, in_last,
    output Mac_out_0, Mac_out_1, Mac_out_2, Mac_out_3,
    output res_ready,
    input  in_ready, Mac_act, Mac_weight, Mac_select, Mac_block,
    input  res_valid, res_data, res_idx, res_last, skip_cnt
  );
endinterface

// File: rtl/mac_feeder.sv
// Feeds a compressed (act, weight, sel) stream into a 4-accumulator MAC,
// dropping zero-operand beats, then at frame end captures the four sums and
// streams them out as idx 0..3.
module mac_feeder #(
  parameter int DATA_WIDTH = 8
) (
  input  logic         Clk,
  input  logic         rst,
  mac_feeder_if.slave  fd_io
);
  localparam int ACC_W = 4 * DATA_WIDTH;

  localparam logic [1:0] ST_ACCUM   = 2'd0;
  localparam logic [1:0] ST_FLUSH   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;

  logic [1:0]                 state_q, state_d;
  logic                       stage_v_q, stage_v_d;
  logic [DATA_WIDTH-1:0]      act_q, act_d;
  logic [DATA_WIDTH-1:0]      wt_q, wt_d;
  logic [1:0]                 sel_q, sel_d;
  logic [1:0]                 idx_q, idx_d;
  logic [3:0][ACC_W-1:0]      cap_q, cap_d;
  logic [15:0]                skip_q, skip_d;

  logic accept, zero_op;
  assign accept  = fd_io.in_valid && (state_q == ST_ACCUM);
  assign zero_op = (fd_io.in_act == '0) || (fd_io.in_weight == '0);

  // next-state: stage load / skip counting, frame FSM, capture, drain index
  always_comb begin
    state_d   = state_q;
    stage_v_d = 1'b0;
    act_d     = act_q;
    wt_d      = wt_q;
    sel_d     = sel_q;
    idx_d     = idx_q;
    cap_d     = cap_q;
    skip_d    = skip_q;
    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          if (!zero_op) begin
            stage_v_d = 1'b1;
            act_d     = fd_io.in_act;
            wt_d      = fd_io.in_weight;
            sel_d     = fd_io.in_sel;
          end else if (skip_q != 16'hFFFF) begin
            skip_d = skip_q + 16'd1;
          end
          if (fd_io.in_last) state_d = ST_FLUSH;
        end
      end
      // stage still holds the final beat this cycle; the MAC absorbs it
      ST_FLUSH: state_d = ST_CAPTURE;
      // MAC exposes its sums this cycle and clears at the same edge
      ST_CAPTURE: begin
        cap_d   = {fd_io.Mac_out_3, fd_io.Mac_out_2, fd_io.Mac_out_1, fd_io.Mac_out_0};
        state_d = ST_DRAIN;
      end
      default: begin
        if (fd_io.res_ready) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = ST_ACCUM;
            skip_d  = '0;
          end
        end
      end
    endcase
  end

  // state registers, synchronous active-low reset discards any partial frame
  always_ff @(posedge Clk) begin
    if (!rst) begin
      state_q   <= ST_ACCUM;
      stage_v_q <= 1'b0;
      act_q     <= '0;
      wt_q      <= '0;
      sel_q     <= '0;
      idx_q     <= '0;
      cap_q     <= '0;
      skip_q    <= '0;
    end else begin
      state_q   <= state_d;
      stage_v_q <= stage_v_d;
      act_q     <= act_d;
      wt_q      <= wt_d;
      sel_q     <= sel_d;
      idx_q     <= idx_d;
      cap_q     <= cap_d;
      skip_q    <= skip_d;
    end
  end

  // an empty stage presents 0*0 to slot 0, a harmless accumulate
  assign fd_io.in_ready   = (state_q == ST_ACCUM);
  assign fd_io.Mac_block  = (state_q != ST_CAPTURE);
  assign fd_io.Mac_act    = stage_v_q ? act_q : '0;
  assign fd_io.Mac_weight = stage_v_q ? wt_q  : '0;
  assign fd_io.Mac_select = stage_v_q ? sel_q : '0;
  assign fd_io.res_valid  = (state_q == ST_DRAIN);
  assign fd_io.res_data   = (state_q == ST_DRAIN) ? cap_q[idx_q] : '0;
  assign fd_io.res_idx    = idx_q;
  assign fd_io.res_last   = (state_q == ST_DRAIN) && (idx_q == 2'd3);
  assign fd_io.skip_cnt   = skip_q;
endmodule

// File: tb/tb_mac_feeder.sv
// Bench for mac_feeder: a behavioural 4-accumulator MAC is attached, frames
// are pushed through, and results are compared with per-frame sums of products.
module tb_mac_feeder;
  localparam int DW = 8;
  localparam int AW = 4 * DW;

  logic Clk = 1'b0;
  logic rst = 1'b0;
  always #5 Clk = ~Clk;

  mac_feeder_if #(.DATA_WIDTH(DW)) bus();
  mac_feeder #(.DATA_WIDTH(DW)) dut (.Clk(Clk), .rst(rst), .fd_io(bus));

  // attached MAC: accumulate while blocked, expose and clear otherwise
  logic [3:0][AW-1:0] acc;
  always @(posedge Clk) begin
    if (!rst) acc <= '0;
    else if (bus.Mac_block)
      acc[bus.Mac_select] <= acc[bus.Mac_select] + AW'(bus.Mac_act) * AW'(bus.Mac_weight);
    else acc <= '0;
  end
  assign bus.Mac_out_0 = acc[0];
  assign bus.Mac_out_1 = acc[1];
  assign bus.Mac_out_2 = acc[2];
  assign bus.Mac_out_3 = acc[3];

  int n_chk = 0;
  int n_fail = 0;

  typedef struct { logic [DW-1:0] a; logic [DW-1:0] w; logic [1:0] s; } beat_t;
  beat_t fq[$];

  logic [AW-1:0] exp_d[4];
  int            exp_skip;

  // observations of one frame
  logic [AW-1:0] o_data[4];
  logic [1:0]    o_idx[4];
  logic          o_last[4];
  int o_skip_pre, o_skip_drain, o_skip_post, o_busy_rdy, o_unstable;
  bit o_lat_ok, o_timeout, o_vld_after, o_rdy_after;

  function automatic void push(input int a, input int w, input int s);
    beat_t b;
    b.a = DW'(a); b.w = DW'(w); b.s = 2'(s);
    fq.push_back(b);
  endfunction

  // reference: per-accumulator sum of products, count of zero-operand beats
  function automatic void model();
    for (int k = 0; k < 4; k++) exp_d[k] = '0;
    exp_skip = 0;
    foreach (fq[i]) begin
      exp_d[fq[i].s] = exp_d[fq[i].s] + AW'(fq[i].a) * AW'(fq[i].w);
      if (fq[i].a == 0 || fq[i].w == 0) exp_skip++;
    end
  endfunction

  // drive fq as one frame, then observe flush/capture/drain
  task automatic run_frame(input int gap_pct, input int stall_pct, input int force_stall0, input bit hold_valid);
    bit v1, v2, v3, rdy;
    int k, cyc, stall0, prev_k;
    logic [AW-1:0] prev_d;
    logic [1:0] prev_i;
    foreach (fq[i]) begin
      @(negedge Clk);
      while ($urandom_range(99) < gap_pct) begin
        bus.in_valid = 1'b0;
        @(negedge Clk);
      end
      bus.in_valid = 1'b1; bus.in_act = fq[i].a; bus.in_weight = fq[i].w;
      bus.in_sel = fq[i].s; bus.in_last = (i == fq.size() - 1);
    end
    o_busy_rdy = 0;
    @(negedge Clk);
    v1 = bus.res_valid; o_skip_pre = bus.skip_cnt; o_busy_rdy += bus.in_ready;
    if (hold_valid) begin
      bus.in_valid = 1'b1; bus.in_act = 8'hA5; bus.in_weight = 8'h3C;
      bus.in_sel = 2'($urandom_range(3)); bus.in_last = 1'b1;
    end else bus.in_valid = 1'b0;
    @(negedge Clk);
    v2 = bus.res_valid; o_busy_rdy += bus.in_ready;
    @(negedge Clk);
    v3 = bus.res_valid;
    o_lat_ok = !v1 && !v2 && v3;
    k = 0; cyc = 0; stall0 = force_stall0; prev_k = -1; o_unstable = 0;
    prev_d = '0; prev_i = '0;
    while (k < 4 && cyc < 200) begin
      o_busy_rdy += bus.in_ready;
      if (k == prev_k && (bus.res_data !== prev_d || bus.res_idx !== prev_i)) o_unstable++;
      prev_k = k; prev_d = bus.res_data; prev_i = bus.res_idx;
      o_data[k] = bus.res_data; o_idx[k] = bus.res_idx; o_last[k] = bus.res_last;
      o_skip_drain = bus.skip_cnt;
      if (stall0 > 0) begin rdy = 1'b0; stall0--; end
      else rdy = ($urandom_range(99) >= stall_pct);
      bus.res_ready = rdy;
      if (rdy && k == 3) bus.in_valid = 1'b0;
      if (rdy) k++;
      @(negedge Clk);
      cyc++;
    end
    o_timeout = (k < 4);
    bus.in_valid = 1'b0; bus.res_ready = 1'b0;
    o_vld_after = bus.res_valid; o_rdy_after = bus.in_ready; o_skip_post = bus.skip_cnt;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge Clk);
    n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %0d expected 1", bus.in_ready); end
    n_chk++; if (bus.Mac_block !== 1'b1) begin n_fail++; $display("FAIL reset Mac_block: got %0d expected 1", bus.Mac_block); end
    n_chk++; if ({bus.Mac_act, bus.Mac_weight, bus.Mac_select} !== '0) begin n_fail++; $display("FAIL reset mac_operands: got %0h expected 0", {bus.Mac_act, bus.Mac_weight, bus.Mac_select}); end
    n_chk++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset res_valid: got %0d expected 0", bus.res_valid); end
    n_chk++; if ({bus.res_data, bus.res_idx, bus.res_last} !== '0) begin n_fail++; $display("FAIL reset res_fields: got %0h expected 0", {bus.res_data, bus.res_idx, bus.res_last}); end
    n_chk++; if (bus.skip_cnt !== 16'd0) begin n_fail++; $display("FAIL reset skip_cnt: got %0d expected 0", bus.skip_cnt); end
    rst = 1'b1;
  endtask

  // fixed frames: basic, skipped beats, stalled drain, back-to-back, held valid
  task automatic test_directed();
    int fs, hv;
    for (int r = 0; r < 6; r++) begin
      fq.delete(); fs = 0; hv = 0;
      case (r)
        0: begin push(3, 4, 0); push(2, 5, 1); push(1, 1, 3); end
        1: begin push(5, 0, 2); push(0, 7, 2); push(6, 6, 2); end
        2: begin push(255, 255, 1); fs = 5; end
        3: push(10, 10, 2);
        4: push(3, 3, 2);
        default: begin push(9, 9, 3); push(2, 2, 0); hv = 1; end
      endcase
      model();
      run_frame(0, 0, fs, hv[0]);
      n_chk++; if (o_timeout) begin n_fail++; $display("FAIL dir%0d drain_timeout: got %0d beats expected 4", r, 0); end
      n_chk++; if (o_lat_ok !== 1'b1) begin n_fail++; $display("FAIL dir%0d res_latency: got %0d expected 1", r, o_lat_ok); end
      n_chk++; if (o_busy_rdy !== 0) begin n_fail++; $display("FAIL dir%0d busy_in_ready: got %0d expected 0", r, o_busy_rdy); end
      n_chk++; if (o_unstable !== 0) begin n_fail++; $display("FAIL dir%0d stall_stability: got %0d expected 0", r, o_unstable); end
      for (int k = 0; k < 4; k++) begin
        n_chk++; if (o_data[k] !== exp_d[k]) begin n_fail++; $display("FAIL dir%0d res_data[%0d]: got %0d expected %0d", r, k, o_data[k], exp_d[k]); end
        n_chk++; if (o_idx[k] !== 2'(k)) begin n_fail++; $display("FAIL dir%0d res_idx[%0d]: got %0d expected %0d", r, k, o_idx[k], k); end
        n_chk++; if (o_last[k] !== (k == 3)) begin n_fail++; $display("FAIL dir%0d res_last[%0d]: got %0d expected %0d", r, k, o_last[k], k == 3); end
      end
      n_chk++; if (o_skip_pre !== exp_skip) begin n_fail++; $display("FAIL dir%0d skip_flush: got %0d expected %0d", r, o_skip_pre, exp_skip); end
      n_chk++; if (o_skip_drain !== exp_skip) begin n_fail++; $display("FAIL dir%0d skip_drain: got %0d expected %0d", r, o_skip_drain, exp_skip); end
      n_chk++; if (o_skip_post !== 0) begin n_fail++; $display("FAIL dir%0d skip_cleared: got %0d expected 0", r, o_skip_post); end
      n_chk++; if (o_vld_after !== 1'b0 || o_rdy_after !== 1'b1) begin n_fail++; $display("FAIL dir%0d back_to_accum: got vld=%0d rdy=%0d expected vld=0 rdy=1", r, o_vld_after, o_rdy_after); end
    end
  endtask

  task automatic test_reset_mid_drain();
    bit hit;
    fq.delete(); push(4, 5, 0); push(0, 3, 1);
    foreach (fq[i]) begin
      @(negedge Clk);
      bus.in_valid = 1'b1; bus.in_act = fq[i].a; bus.in_weight = fq[i].w;
      bus.in_sel = fq[i].s; bus.in_last = (i == fq.size() - 1);
    end
    @(negedge Clk); bus.in_valid = 1'b0;
    @(negedge Clk);
    @(negedge Clk); bus.res_ready = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 10 && !hit; c++) begin
      if (bus.res_valid && bus.res_idx == 2'd2) hit = 1'b1;
      else @(negedge Clk);
    end
    n_chk++; if (!hit) begin n_fail++; $display("FAIL rst_drain reach_idx2: got %0d expected 1", hit); end
    rst = 1'b0; bus.res_ready = 1'b0;
    @(negedge Clk);
    n_chk++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_drain res_valid: got %0d expected 0", bus.res_valid); end
    n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_drain in_ready: got %0d expected 1", bus.in_ready); end
    n_chk++; if (bus.skip_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_drain skip_cnt: got %0d expected 0", bus.skip_cnt); end
    rst = 1'b1;
    fq.delete(); push(2, 3, 0);
    model();
    run_frame(0, 0, 0, 1'b0);
    n_chk++; if (o_timeout) begin n_fail++; $display("FAIL rst_drain post_timeout: got %0d expected 0", o_timeout); end
    for (int k = 0; k < 4; k++) begin
      n_chk++; if (o_data[k] !== exp_d[k]) begin n_fail++; $display("FAIL rst_drain post_data[%0d]: got %0d expected %0d", k, o_data[k], exp_d[k]); end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      fq.delete();
      for (int b = 0, n = $urandom_range(1, 8); b < n; b++)
        push(($urandom_range(3) == 0) ? 0 : $urandom_range(1, 255),
             ($urandom_range(3) == 0) ? 0 : $urandom_range(1, 255), $urandom_range(3));
      model();
      run_frame(30, 30, 0, 1'($urandom_range(1)));
      n_chk++; if (o_timeout) begin n_fail++; $display("FAIL rnd%0d drain_timeout: got %0d expected 0", f, o_timeout); end
      n_chk++; if (o_lat_ok !== 1'b1) begin n_fail++; $display("FAIL rnd%0d res_latency: got %0d expected 1", f, o_lat_ok); end
      n_chk++; if (o_busy_rdy !== 0 || o_unstable !== 0) begin n_fail++; $display("FAIL rnd%0d busy_or_unstable: got %0d/%0d expected 0/0", f, o_busy_rdy, o_unstable); end
      for (int k = 0; k < 4; k++) begin
        n_chk++; if (o_data[k] !== exp_d[k] || o_idx[k] !== 2'(k) || o_last[k] !== (k == 3)) begin
          n_fail++; $display("FAIL rnd%0d res[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", f, k, o_data[k], o_idx[k], o_last[k], exp_d[k], k, k == 3);
        end
      end
      n_chk++; if (o_skip_drain !== exp_skip || o_skip_post !== 0) begin n_fail++; $display("FAIL rnd%0d skip_cnt: got %0d/%0d expected %0d/0", f, o_skip_drain, o_skip_post, exp_skip); end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_act = '0; bus.in_weight = '0; bus.in_sel = '0;
    bus.in_last = 1'b0; bus.res_ready = 1'b0;
    test_reset();
    test_directed();
    test_reset_mid_drain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
